sobel_frame_ctrl: RTL

//  Frame/line sequencer in front of sobel_processor. Tracks vsync/href, counts rows and columns,
//  and switches the Sobel/bypass mode only at a frame boundary so a frame is never mixed-mode.

---
 rtl/sobel_frame_ctrl_if.sv | 31 +++
 rtl/sobel_frame_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/sobel_frame_ctrl_if.sv
// Video timing and status bundle between the frame sequencer and its video source.
// The source drives the master side; sobel_frame_ctrl takes the slave side.
interface sobel_frame_ctrl_if #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
);
  localparam int CW = $clog2(IMG_HEIGHT + 1);
  localparam int WW = $clog2(IMG_WIDTH + 1);

  logic          vsync;
  logic          href;
  logic          mode_req;
  logic          mode_sobel;
  logic [CW-1:0] row;
  logic [WW-1:0] col;
  logic          frame_start;
  logic          frame_done;
  logic          frame_err;
  logic          line_err;
  logic          busy;

  modport master (
    output vsync, href, mode_req,
    input  mode_sobel, row, col, frame_start, frame_done, frame_err, line_err, busy
  );

  modport slave (
    input  vsync, href, mode_req,
    output mode_sobel, row, col, frame_start, frame_done, frame_err, line_err, busy
  );
endinterface

// File: rtl/sobel_frame_ctrl.sv
// Frame/line sequencer ahead of sobel_processor: tracks vsync/href, counts rows and
// columns, latches the Sobel/bypass mode per frame and drains before reporting completion.
module sobel_frame_ctrl #(
  parameter int IMG_WIDTH    = 640,
  parameter int IMG_HEIGHT   = 480,
  parameter int DRAIN_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  sobel_frame_ctrl_if.slave  fc
);
  localparam int CW   = $clog2(IMG_HEIGHT + 1);
  localparam int WW   = $clog2(IMG_WIDTH + 1);
  localparam int CNTW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [CW-1:0]   LAST_ROW  = CW'(IMG_HEIGHT - 1);
  localparam logic [WW-1:0]   LINE_LEN  = WW'(IMG_WIDTH);
  localparam logic [CNTW-1:0] DRAIN_TOP = CNTW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SYNC, WAIT_LINE, LINE, DRAIN} state_t;

  state_t          state_q, state_d;
  logic            vs_q, hr_q;
  logic            vs_rise, vs_fall, hr_fall;
  logic [CNTW-1:0] cnt_q;
  logic [CW-1:0]   row_q;
  logic [WW-1:0]   col_q;
  logic            mode_q, line_err_q;
  logic            start_q, done_q, err_q;
  logic            start_d, done_d, err_d;
  logic            line_end, last_row, cnt_zero;

  // Column counter holds at its maximum rather than wrapping on overlong lines.
  function automatic logic [WW-1:0] sat_inc(input logic [WW-1:0] v);
    return (&v) ? v : v + WW'(1);
  endfunction

  assign vs_rise  = fc.vsync & ~vs_q;
  assign vs_fall  = ~fc.vsync & vs_q;
  assign hr_fall  = ~fc.href & hr_q;
  assign last_row = (row_q == LAST_ROW);
  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (fc.vsync) state_d = SYNC;
      SYNC:      if (vs_fall) state_d = WAIT_LINE;
      WAIT_LINE: if (vs_rise) state_d = SYNC;
                 else if (fc.href) state_d = LINE;
      LINE:      if (vs_rise) state_d = SYNC;
                 else if (hr_fall) state_d = last_row ? DRAIN : WAIT_LINE;
      DRAIN:     if (vs_rise) state_d = SYNC;
                 else if (cnt_zero) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // A vsync rise always overrides a coincident line end.
  always_comb begin
    start_d  = (state_q == SYNC) && vs_fall;
    err_d    = ((state_q == WAIT_LINE) || (state_q == LINE)) && vs_rise;
    done_d   = (state_q == DRAIN) && (vs_rise || cnt_zero);
    line_end = (state_q == LINE) && !vs_rise && hr_fall;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q       <= 1'b0;
      hr_q       <= 1'b0;
      mode_q     <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      line_err_q <= 1'b0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      vs_q    <= fc.vsync;
      hr_q    <= fc.href;
      start_q <= start_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (start_d) begin
        mode_q     <= fc.mode_req;
        row_q      <= '0;
        col_q      <= '0;
        line_err_q <= 1'b0;
      end
      if ((state_q == WAIT_LINE) && !vs_rise && fc.href) col_q <= WW'(1);
      if ((state_q == LINE) && !vs_rise && fc.href) col_q <= sat_inc(col_q);
      if (line_end) begin
        if (col_q != LINE_LEN) line_err_q <= 1'b1;
        if (!last_row) begin
          row_q <= row_q + CW'(1);
          col_q <= '0;
        end
      end
    end
  end

  // Drain counter is only read in DRAIN and is always loaded on entry.
  always_ff @(posedge clk) begin
    if (line_end && last_row)                 cnt_q <= DRAIN_TOP;
    else if ((state_q == DRAIN) && !cnt_zero) cnt_q <= cnt_q - CNTW'(1);
  end

  assign fc.mode_sobel  = mode_q;
  assign fc.row         = row_q;
  assign fc.col         = col_q;
  assign fc.frame_start = start_q;
  assign fc.frame_done  = done_q;
  assign fc.frame_err   = err_q;
  assign fc.line_err    = line_err_q;
  assign fc.busy        = (state_q != IDLE);
endmodule
